// File: rtl/packet_serializer.sv
// -----------------------------------------------------------------------------
// packet_serializer
//
// Purpose:
//   Accepts one complete wide packet (header + ADC payload) in a single-cycle
//   write and streams it byte by byte, byte 0 first, into a byte-wide TX FIFO.
//   FIFO-full backpressure is honoured. The busy output feeds the upstream
//   packer's "full" input so that a new packet is only offered once the
//   previous one has drained.
//
// Optional feature:
//   PACKET_SERIALIZER_CHECKSUM_EN - when defined, a running XOR over all
//   pPacketSize transmitted bytes is appended as one extra trailing byte.
//   When undefined, exactly pPacketSize bytes are written per packet.
//
// Ports:
//   iClk          in   1               system clock, rising edge
//   iRst_n        in   1               asynchronous active-low reset
//   iPacketWr     in   1               single-cycle packet write strobe
//   iPacketData   in   pPacketSize*8   packet, byte k = bits [8k+7:8k]
//   oBusy         out  1               packet held / in transmission
//   oWrEn         out  1               FIFO write strobe
//   oWrData       out  pFifoBitWidth   FIFO write data
//   iWrFull       in   1               FIFO full, no write while high
//   oErr          out  1               sticky: strobe arrived while busy
//   oPacketsSent  out  16              completed-packet counter (wraps)
// -----------------------------------------------------------------------------
module packet_serializer #(
  parameter int pPacketSize   = 244,
  parameter int pFifoBitWidth = 8
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iPacketWr,
  input  logic [pPacketSize*8-1:0]   iPacketData,
  output logic                       oBusy,
  output logic                       oWrEn,
  output logic [pFifoBitWidth-1:0]   oWrData,
  input  logic                       iWrFull,
  output logic                       oErr,
  output logic [15:0]                oPacketsSent
);

  localparam int PktBits = pPacketSize * 8;
  localparam int CntW    = $clog2(pPacketSize + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(pPacketSize - 1);

`ifdef PACKET_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DONE  = 2'd2,
    CKSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t                state_reg, state_next;
  logic [PktBits-1:0]    shift_reg, shift_next;
  logic [CntW-1:0]       cnt_reg, cnt_next;
  logic                  err_reg;
  logic [15:0]           sent_reg;
  logic                  wr_en;
  logic [7:0]            wr_byte;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
  logic [7:0]            cksum_reg, cksum_next;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    wr_en      = 1'b0;
    // The shift register's low byte is always the next byte to go out; it is
    // also what the bus shows in IDLE/DONE (all zero once a packet drains).
    wr_byte    = shift_reg[7:0];
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
    cksum_next = cksum_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (iPacketWr) begin
          shift_next = iPacketData;
          cnt_next   = '0;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
          cksum_next = 8'h00;
`endif
          state_next = SEND;
        end
      end

      SEND: begin
        // Combinational from iWrFull so a write can happen in the very cycle
        // the FIFO reports space.
        wr_en = !iWrFull;
        if (wr_en) begin
          shift_next = {8'h00, shift_reg[PktBits-1:8]};
          cnt_next   = cnt_reg + 1'b1;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
          cksum_next = cksum_reg ^ shift_reg[7:0];
`endif
          if (cnt_reg == LastIdx) begin
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
            state_next = CKSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end

`ifdef PACKET_SERIALIZER_CHECKSUM_EN
      CKSUM: begin
        wr_en   = !iWrFull;
        wr_byte = cksum_reg;
        if (wr_en) begin
          state_next = DONE;
        end
      end
`endif

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
      cksum_reg <= 8'h00;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
      cksum_reg <= cksum_next;
`endif
    end
  end

  // A strobe outside IDLE is dropped; only the sticky flag records it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      err_reg <= 1'b0;
    end else if (iPacketWr && (state_reg != IDLE)) begin
      err_reg <= 1'b1;
    end
  end

  // Counts in the single DONE cycle; natural 16-bit wrap.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sent_reg <= 16'h0000;
    end else if (state_reg == DONE) begin
      sent_reg <= sent_reg + 16'h0001;
    end
  end

  assign oBusy        = (state_reg != IDLE);
  assign oWrEn        = wr_en;
  assign oWrData      = pFifoBitWidth'(wr_byte);
  assign oErr         = err_reg;
  assign oPacketsSent = sent_reg;

endmodule

// File: tb/tb_packet_serializer.sv
module tb_packet_serializer;

  localparam int N = 244;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NB = N + EXTRA;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pkt_wr = 1'b0;
  logic [N*8-1:0]   pkt_data = '0;
  logic             wr_full = 1'b0;
  logic             busy;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             err;
  logic [15:0]      sent;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  packet_serializer #(.pPacketSize(N), .pFifoBitWidth(8)) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iPacketWr   (pkt_wr),
    .iPacketData (pkt_data),
    .oBusy       (busy),
    .oWrEn       (wr_en),
    .oWrData     (wr_data),
    .iWrFull     (wr_full),
    .oErr        (err),
    .oPacketsSent(sent)
  );

  always #5 clk = ~clk;

  // mode 0: byte k = k, 1: byte k = 255-k, 3: 5A then zeros, 4: all A5
  function automatic logic [N*8-1:0] make_pkt(input int mode);
    logic [N*8-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: p[8*k +: 8] = 8'(k);
        1: p[8*k +: 8] = 8'(255 - k);
        3: p[8*k +: 8] = (k == 0) ? 8'h5A : 8'h00;
        default: p[8*k +: 8] = 8'hA5;
      endcase
    end
    return p;
  endfunction

  task automatic build_expected(input logic [N*8-1:0] p);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(p[8*k +: 8]);
      x = x ^ p[8*k +: 8];
    end
    if (EXTRA == 1) exp_q.push_back(x);
  endtask

  // Returns first mismatching index, -1 when rx equals exp_q.
  function automatic int first_diff();
    if (rx.size() != exp_q.size()) return -2;
    for (int i = 0; i < rx.size(); i++)
      if (rx[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    pkt_wr = 1'b0;
    wr_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one packet and records the byte stream plus timing. Cycle 1 is the
  // first cycle after the capturing edge.
  task automatic run_xfer(input logic [N*8-1:0] p, input bit toggle, input int err_at,
                          output int first_w, output int last_w, output int idle_c,
                          output int full_bad, output int hold_bad);
    bit         stalled;
    bit         err_done;
    logic [7:0] held;
    rx.delete();
    first_w = -1; last_w = -1; idle_c = -1; full_bad = 0; hold_bad = 0;
    stalled = 1'b0; err_done = 1'b0; held = 8'h00;
    pkt_data = p;
    pkt_wr = 1'b1;
    wr_full = 1'b0;
    @(negedge clk);
    for (int c = 1; c < 4000; c++) begin
      wr_full = toggle ? (c % 2 == 1) : 1'b0;
      if (err_at >= 0 && rx.size() == err_at && !err_done) begin
        pkt_wr = 1'b1;
        pkt_data = {N{8'hFF}};
        err_done = 1'b1;
      end else begin
        pkt_wr = 1'b0;
        pkt_data = p;
      end
      #1;
      if (stalled && wr_data !== held) hold_bad++;
      stalled = busy && wr_full && (rx.size() < NB);
      held = wr_data;
      if (wr_en && wr_full) full_bad++;
      if (wr_en) begin
        rx.push_back(wr_data);
        if (first_w < 0) first_w = c;
        last_w = c;
      end
      if (!busy) begin
        idle_c = c;
        break;
      end
      @(negedge clk);
    end
    pkt_wr = 1'b0;
    wr_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b want 0", wr_en); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wrdata got %h want 00", wr_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (sent !== 16'h0) begin n_bad++; $display("FAIL reset_sent got %h want 0000", sent); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Start a packet, provoke an error, then reset mid-cycle.
    pkt_data = make_pkt(0);
    pkt_wr = 1'b1;
    @(negedge clk);
    pkt_wr = 1'b0;
    repeat (2) @(negedge clk);
    pkt_wr = 1'b1;
    @(negedge clk);
    pkt_wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (err !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_state got err=%b busy=%b want 1 1", err, busy); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midreset_wren got %b want 0", wr_en); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL midreset_wrdata got %h want 00", wr_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midreset_err got %b want 0", err); end
    n_cmp++; if (sent !== 16'h0) begin n_bad++; $display("FAIL midreset_sent got %h want 0000", sent); end
    $display("test_reset: done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int fw, lw, ic, fb, hb, d;
    do_reset();
    build_expected(make_pkt(0));
    run_xfer(make_pkt(0), 1'b0, -1, fw, lw, ic, fb, hb);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL single_bytes got size=%0d diff_at=%0d want size=%0d diff_at=-1", rx.size(), d, NB); end
    n_cmp++; if (fw != 1) begin n_bad++; $display("FAIL single_first_write got cycle %0d want 1", fw); end
    n_cmp++; if (lw != NB) begin n_bad++; $display("FAIL single_last_write got cycle %0d want %0d", lw, NB); end
    n_cmp++; if (ic != NB + 2) begin n_bad++; $display("FAIL single_busy_fall got cycle %0d want %0d", ic, NB + 2); end
    n_cmp++; if (sent !== 16'd1) begin n_bad++; $display("FAIL single_sent got %0d want 1", sent); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err); end
    $display("test_single: %0d bytes, last write cycle %0d, idle cycle %0d", rx.size(), lw, ic);
  endtask

  task automatic test_backpressure();
    int fw, lw, ic, fb, hb, d;
    do_reset();
    build_expected(make_pkt(0));
    run_xfer(make_pkt(0), 1'b1, -1, fw, lw, ic, fb, hb);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL bp_bytes got size=%0d diff_at=%0d want size=%0d diff_at=-1", rx.size(), d, NB); end
    n_cmp++; if (fw != 2) begin n_bad++; $display("FAIL bp_first_write got cycle %0d want 2", fw); end
    n_cmp++; if (lw != 2 * NB) begin n_bad++; $display("FAIL bp_last_write got cycle %0d want %0d", lw, 2 * NB); end
    n_cmp++; if (fb != 0) begin n_bad++; $display("FAIL bp_write_while_full got %0d want 0", fb); end
    n_cmp++; if (hb != 0) begin n_bad++; $display("FAIL bp_data_hold got %0d changes want 0", hb); end
    n_cmp++; if (sent !== 16'd1) begin n_bad++; $display("FAIL bp_sent got %0d want 1", sent); end
    $display("test_backpressure: %0d bytes, last write cycle %0d", rx.size(), lw);
  endtask

  task automatic test_overlap();
    int fw, lw, ic, fb, hb, d;
    do_reset();
    build_expected(make_pkt(0));
    run_xfer(make_pkt(0), 1'b0, 50, fw, lw, ic, fb, hb);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL overlap_bytes got size=%0d diff_at=%0d want size=%0d diff_at=-1", rx.size(), d, NB); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL overlap_err got %b want 1", err); end
    n_cmp++; if (sent !== 16'd1) begin n_bad++; $display("FAIL overlap_sent got %0d want 1", sent); end
    $display("test_overlap: %0d bytes, err=%b", rx.size(), err);
    // Back-to-back: strobe in the very first idle cycle must be accepted.
    build_expected(make_pkt(1));
    run_xfer(make_pkt(1), 1'b0, -1, fw, lw, ic, fb, hb);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL b2b_bytes got size=%0d diff_at=%0d want size=%0d diff_at=-1", rx.size(), d, NB); end
    n_cmp++; if (sent !== 16'd2) begin n_bad++; $display("FAIL b2b_sent got %0d want 2", sent); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    $display("test_back_to_back: %0d bytes, sent=%0d", rx.size(), sent);
  endtask

  task automatic test_reset_mid();
    int fw, lw, ic, fb, hb, d, nw;
    bit reached;
    do_reset();
    nw = 0;
    reached = 1'b0;
    pkt_data = make_pkt(0);
    pkt_wr = 1'b1;
    @(negedge clk);
    pkt_wr = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      if (wr_en) nw++;
      if (nw == 101) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL midpkt_progress got %0d writes want 101", nw); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL midpkt_abort got busy=%b wren=%b want 0 0", busy, wr_en); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_expected(make_pkt(1));
    run_xfer(make_pkt(1), 1'b0, -1, fw, lw, ic, fb, hb);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL midpkt_restart_bytes got size=%0d diff_at=%0d want size=%0d diff_at=-1", rx.size(), d, NB); end
    n_cmp++; if (fw != 1) begin n_bad++; $display("FAIL midpkt_first_write got cycle %0d want 1", fw); end
    n_cmp++; if (sent !== 16'd1) begin n_bad++; $display("FAIL midpkt_sent got %0d want 1", sent); end
    $display("test_reset_mid: restart %0d bytes, first byte %h", rx.size(), (rx.size() > 0) ? rx[0] : 8'h00);
  endtask

`ifdef PACKET_SERIALIZER_CHECKSUM_EN
  task automatic test_checksum();
    int fw, lw, ic, fb, hb;
    do_reset();
    run_xfer(make_pkt(3), 1'b0, -1, fw, lw, ic, fb, hb);
    n_cmp++; if (rx.size() != 245) begin n_bad++; $display("FAIL cksum1_len got %0d want 245", rx.size()); end
    n_cmp++; if (rx.size() != 245 || rx[244] !== 8'h5A) begin n_bad++; $display("FAIL cksum1_value got %h want 5a", (rx.size() == 245) ? rx[244] : 8'hxx); end
    run_xfer(make_pkt(4), 1'b0, -1, fw, lw, ic, fb, hb);
    n_cmp++; if (rx.size() != 245 || rx[244] !== 8'h00) begin n_bad++; $display("FAIL cksum2_value got %h want 00", (rx.size() == 245) ? rx[244] : 8'hxx); end
    $display("test_checksum: %0d bytes, checksum %h", rx.size(), (rx.size() > 0) ? rx[rx.size()-1] : 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overlap();
    test_reset_mid();
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
# packet_serializer

Downstream stage of `adc_to_packet`. Accepts one complete wide packet (4-byte header plus ADC sample payload) in a single-cycle write, then streams it byte by byte into the byte-wide USB/UART TX FIFO, honouring FIFO-full backpressure. While a packet is in flight, the block drives its busy output. That output connects to `adc_to_packet`'s `iPackerWrFull`.

## Interface
Parameters:
- `pPacketSize`, 244, packet length in bytes (header + payload).
- `pFifoBitWidth`, 8, output word width. Only 8 is supported.

Ports (one clock; reset is asynchronous and active-low):
- `iClk`  in  1  system clock, rising-edge.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iPacketWr`  in  1  single-cycle strobe; `iPacketData` valid this cycle.
- `iPacketData`  in  pPacketSize*8  packet. Byte k = bits [8k+7:8k]. Byte 0 is the first header byte.
- `oBusy`  out  1  packet held or in transmission. Feeds upstream full.
- `oWrEn`  out  1  FIFO write strobe.
- `oWrData`  out  pFifoBitWidth  FIFO write data.
- `iWrFull`  in  1  FIFO full; no write may occur while high.
- `oErr`  out  1  sticky. Set when `iPacketWr` arrives while `oBusy` is high.
- `oPacketsSent`  out  16  completed-packet counter.

## Operation
- Registered state: an internal shift register, pPacketSize*8 bits wide; a byte counter, $clog2(pPacketSize+1) bits; and the state.
- FSM states:
  - **IDLE**: `oBusy`=0. On `iPacketWr`=1, capture `iPacketData` into the shift register, clear the counter, and go to SEND.
  - **SEND**: `oWrEn` = !`iWrFull` (combinational), and `oWrData` = shift register [7:0].
    - On each edge where `oWrEn`=1, shift right 8 bits and increment the counter.
    - When the write of byte pPacketSize-1 occurs, go to CKSUM if the checksum is compiled in, otherwise go to DONE.
  - **CKSUM** (macro only): `oWrEn` = !`iWrFull`, and `oWrData` = checksum. On the write, go to DONE.
  - **DONE**: one cycle. `oPacketsSent` += 1 (wraps 0xFFFF -> 0x0000). Return to IDLE.
- `oBusy` = 1 in SEND, CKSUM and DONE.
- `iPacketWr` while not IDLE:
  - The packet is dropped.
  - `oErr` <= 1.
  - The in-flight packet is unaffected.
  - `oErr` clears only on reset.
- Byte order: byte 0 first, through byte pPacketSize-1. Bytes are never reordered, duplicated or skipped.
- `iWrFull` high for any number of cycles stalls the block with no data loss. `oWrData` holds its value while stalled.

## Timing
- Reset values (async assert):
  - state = IDLE.
  - `oBusy`=0, `oWrEn`=0, `oWrData`=0, `oErr`=0, `oPacketsSent`=0.
  - Shift register, counter and checksum = 0.
- `iPacketWr` sampled at edge E0. `oBusy`=1 and the first `oWrEn` are both visible in the cycle after E0.
- No backpressure: pPacketSize consecutive `oWrEn` cycles (+1 with the checksum). DONE is then one cycle, and `oBusy`=0 one cycle after DONE.
- Next packet acceptance: earliest in the first cycle with `oBusy`=0. A strobe coincident with DONE is an error drop.
- Reset mid-packet: the transfer aborts immediately and the partial packet is lost. After reset release, the FSM is in IDLE and the next packet starts at byte 0.
- `oWrEn` is never high while `iWrFull` is high.

## Configuration
- `PACKET_SERIALIZER_CHECKSUM_EN`:
  - **Defined**: a running XOR is maintained over all pPacketSize transmitted bytes, updated on each SEND write and cleared on capture. It is appended as byte pPacketSize, so the transfer is pPacketSize+1 bytes.
  - **Undefined**: no CKSUM state and no checksum register. Exactly pPacketSize bytes are written per packet.

## Test plan
1. **Reset values.** Assert `iRst_n`=0 asynchronously mid-cycle -> all outputs go to their reset values before the next edge.
2. **Single packet, no backpressure.** Byte k = k (0..243) and `iWrFull`=0 -> 244 consecutive writes with `oWrData`=0x00..0xF3. `oBusy` falls 2 cycles after the last write, and `oPacketsSent`=1.
3. **Toggled backpressure.** Same packet, with `iWrFull` toggling every cycle -> identical byte sequence, `oWrEn`=0 on every full cycle, and the transfer completes in 488 cycles.
4. **Overlapping strobe.** Second `iPacketWr` (all 0xFF) during byte 50 -> `oErr`=1 and stays 1. The first packet completes unchanged, no 0xFF bytes appear, and `oPacketsSent`=1.
5. **Reset mid-packet.** `iRst_n` low after byte 100, then a new packet -> output restarts at byte 0 and carries the new data. `oPacketsSent`=1 after it completes.
6. **Checksum (macro defined).** Byte 0 = 0x5A, rest 0x00 -> 245 writes, with the last byte = 0x5A. Then bytes all 0xA5 -> last byte = 0x00.
